round_scoreboard: RTL

- Match controller that sits downstream of the per-round win detector and consumes its 2-bit winner code.
- Registers each new round win and keeps per-player round scores, displayed as decimal digits on two seven-segment displays.
- Holds a celebration window after each win, then drives a round-restart pulse back to the playfield and win detector.
- Declares the match winner once a player reaches WIN_SCORE, and freezes play until both players press their keys to start a new match.

---
 rtl/round_scoreboard.sv | 130 +++++++++++++
 1 files changed

// File: rtl/round_scoreboard.sv
// Match controller: counts round wins per player, holds a celebration window,
// restarts rounds, and freezes on a match win until both keys are pressed.

module round_seg7 (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  // Active-low {g,f,e,d,c,b,a}; codes above 9 blank the display.
  always_comb begin
    seg = 7'b1111111;
    case (digit)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

module round_scoreboard #(
  parameter int HOLD_CYCLES = 8,
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] winner,
  input  logic       L,
  input  logic       R,
  output logic       round_rst,
  output logic [1:0] celebrate,
  output logic [3:0] lscore,
  output logic [3:0] rscore,
  output logic [6:0] hex_l,
  output logic [6:0] hex_r,
  output logic       match_over,
  output logic [1:0] match_winner
);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [3:0]        WIN       = 4'(WIN_SCORE);

  typedef enum logic [1:0] {PLAY, HOLD, CLEAR, DONE} state_t;

  state_t            state, state_nx;
  logic [HOLD_W-1:0] cnt;
  // Player index matches the winner code bit: [0] right, [1] left.
  logic [1:0][3:0]   score;
  logic [1:0]        rwin;
  logic [1:0]        win_pick;
  logic [1:0][6:0]   segs;
  logic              hold_last, at_win, new_match;

  assign hold_last = (cnt == HOLD_LAST);
  assign at_win    = |(rwin & {score[1] == WIN, score[0] == WIN});

  always_ff @(posedge clk) begin
    if (!reset) state <= CLEAR;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    win_pick     = 2'b00;
    new_match    = 1'b0;
    round_rst    = 1'b0;
    celebrate    = 2'b00;
    match_over   = 1'b0;
    match_winner = 2'b00;
    case (state)
      PLAY: begin
        if (winner == 2'b01 || winner == 2'b10) begin
          win_pick = winner;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        celebrate = rwin;
        if (hold_last) state_nx = at_win ? DONE : CLEAR;
      end
      CLEAR: begin
        round_rst = 1'b1;
        if (winner == 2'b00) state_nx = PLAY;
      end
      DONE: begin
        round_rst    = 1'b1;
        match_over   = 1'b1;
        match_winner = rwin;
        if (L && R) begin
          new_match = 1'b1;
          state_nx  = CLEAR;
        end
      end
      default: state_nx = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= '0;
      rwin  <= 2'b00;
      score <= '0;
    end else begin
      cnt <= (state == HOLD && !hold_last) ? cnt + HOLD_W'(1) : '0;
      if (new_match) begin
        score <= '0;
        rwin  <= 2'b00;
      end else if (win_pick != 2'b00) begin
        rwin <= win_pick;
        for (int i = 0; i < 2; i++)
          if (win_pick[i]) score[i] <= score[i] + 4'd1;
      end
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_seg
    round_seg7 u_seg (.digit(score[i]), .seg(segs[i]));
  end

  assign rscore = score[0];
  assign lscore = score[1];
  assign hex_r  = segs[0];
  assign hex_l  = segs[1];
endmodule
